univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Localparam CW, fixed at $clog2(WIDTH), SHALL set the shift-counter width.
REQ-003 Port clk, input, 1, the block's single clock; all state SHALL update on its rising edge.
REQ-004 Port clr, input, 1, asynchronous active-high reset.
REQ-005 Port en, input, 1, clock enable; the block SHALL hold all state when low.
REQ-006 Port mode, input, 2, operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port d, input, WIDTH, parallel load data.
REQ-008 Port sin_r, input, 1, serial data entering the MSB on a right shift.
REQ-009 Port sin_l, input, 1, serial data entering the LSB on a left shift.
REQ-010 Port q, output, WIDTH, register contents.
REQ-011 Port sout_r, output, 1, SHALL equal q[0] combinationally.
REQ-012 Port sout_l, output, 1, SHALL equal q[WIDTH-1] combinationally.
REQ-013 Port cnt, output, CW, number of shifts since the last load or reset, modulo WIDTH.
REQ-014 Port word_done, output, 1, registered one-cycle pulse marking completion of WIDTH shifts.

Function
REQ-015 With en=1 and mode=01, the block SHALL load q <= {sin_r, q[WIDTH-1:1]} at the clock edge.
REQ-016 With en=1 and mode=10, the block SHALL load q <= {q[WIDTH-2:0], sin_l} at the clock edge.
REQ-017 With en=1 and mode=11, the block SHALL load q <= d and cnt <= 0, and SHALL drive word_done to 0, with single-cycle latency.
REQ-018 With en=1 and mode=00, or with en=0, the block SHALL leave q and cnt unchanged and SHALL drive word_done to 0.
REQ-019 Each shift in either direction SHALL increment cnt.
REQ-020 A direction change SHALL NOT clear cnt.
REQ-021 On the shift edge where cnt = WIDTH-1, cnt SHALL wrap to 0 and word_done SHALL be set to 1 for exactly the following cycle.
REQ-022 On back-to-back words (continuous shifting), word_done SHALL pulse once every WIDTH shifts, with no gap cycles required.
REQ-023 A load issued mid-word SHALL restart counting, and the discarded partial word SHALL NOT produce a word_done pulse.

Reset
REQ-024 Asserting clr SHALL immediately, without a clock edge, force q=0, cnt=0 and word_done=0; sout_r and sout_l are therefore 0.
REQ-025 clr SHALL override en and mode.
REQ-026 The first operation after deassertion of clr SHALL take effect at the first rising clk edge with clr low.

Configuration
REQ-027 The block SHALL provide a rotate feature compiled in by macro USR_ROTATE_EN.
REQ-028 With USR_ROTATE_EN defined, a port rot (input, 1) SHALL exist, and rot=1 SHALL replace sin_r by q[0] on right shifts and sin_l by q[WIDTH-1] on left shifts; cnt and word_done behaviour SHALL be unchanged.
REQ-029 Without USR_ROTATE_EN, the rot port and the rotate logic SHALL NOT exist, and shifts SHALL always use sin_r and sin_l.

Structure
REQ-030 Shared package usr_pkg SHALL hold the mode encoding typedef (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the default WIDTH constant.
REQ-031 The shift counter and word_done generation SHALL be a sub-module usr_shift_cnt (inputs: shift strobe, load strobe; outputs: cnt, word_done), instantiated once.

Verification
REQ-032 WIDTH=8: load d=8'hA5, then one right shift with sin_r=0 -> q=8'h52 and sout_r=0; q=8'hA5 with cnt=0 after the load edge.
REQ-033 From reset, eight left shifts with sin_l=1 -> q=8'hFF, cnt=0, and word_done high only in the cycle after the 8th shift; a 9th shift -> cnt=1 and word_done=0.
REQ-034 After three shifts (cnt=3), assert clr between clock edges -> q=0, cnt=0 and word_done=0 before the next edge.
REQ-035 en=0 with mode=11 and d=8'h3C for 4 cycles -> q and cnt unchanged, and word_done=0.
REQ-036 Five shifts, then a load of 8'h0F, then seven shifts -> no word_done pulse and cnt=7; the 8th shift after the load -> word_done pulses.
REQ-037 With USR_ROTATE_EN: load 8'h81, then rot=1 right shift -> q=8'hC0; rot=1 left shift from 8'h81 -> q=8'h03.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: shared mode encoding and default width for the universal shift register
package usr_pkg;
    localparam int USR_WIDTH = 8;
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;
endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control/data bundle of the universal shift register; rot exists only with USR_ROTATE_EN
interface univ_shift_reg_if #(parameter int WIDTH = usr_pkg::USR_WIDTH);
    import usr_pkg::*;
    localparam int CW = $clog2(WIDTH);
    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
`ifdef USR_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    cnt;
    logic             word_done;
    modport master (
        output en, mode, d, sin_r, sin_l,
`ifdef USR_ROTATE_EN
        output rot,
`endif
        input  q, sout_r, sout_l, cnt, word_done
    );
    modport slave (
        input  en, mode, d, sin_r, sin_l,
`ifdef USR_ROTATE_EN
        input  rot,
`endif
        output q, sout_r, sout_l, cnt, word_done
    );
endinterface

// File: rtl/usr_shift_cnt.sv
// usr_shift_cnt: counts shifts modulo WIDTH and pulses word_done after each full word
module usr_shift_cnt #(
    parameter int WIDTH = usr_pkg::USR_WIDTH,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          shift,
    input  logic          load,
    output logic [CW-1:0] cnt,
    output logic          word_done
);
    logic last;
    assign last = cnt == CW'(WIDTH - 1);
    // counter wraps explicitly so non-power-of-two widths still count modulo WIDTH
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            cnt       <= load ? '0 : shift ? (last ? '0 : cnt + 1'b1) : cnt;
            word_done <= shift && last;
        end
    end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: hold/shift-right/shift-left/load register with word counter; USR_ROTATE_EN adds rotate via rot
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_WIDTH
) (
    input  logic            clk,
    input  logic            clr,
    univ_shift_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] q, q_nxt;
    logic [CW-1:0]    cnt;
    logic             word_done, in_r, in_l, shift, load;
`ifdef USR_ROTATE_EN
    assign in_r = bus.rot ? q[0] : bus.sin_r;
    assign in_l = bus.rot ? q[WIDTH-1] : bus.sin_l;
`else
    assign in_r = bus.sin_r;
    assign in_l = bus.sin_l;
`endif
    assign shift = bus.en && (bus.mode == MODE_SHR || bus.mode == MODE_SHL);
    assign load  = bus.en && bus.mode == MODE_LOAD;
    // select the next register value from enable and mode
    always_comb begin
        q_nxt = !bus.en                ? q :
                bus.mode == MODE_SHR  ? {in_r, q[WIDTH-1:1]} :
                bus.mode == MODE_SHL  ? {q[WIDTH-2:0], in_l} :
                bus.mode == MODE_LOAD ? bus.d : q;
    end
    // data register, cleared asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) q <= '0;
        else     q <= q_nxt;
    end
    usr_shift_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk       (clk),
        .clr       (clr),
        .shift     (shift),
        .load      (load),
        .cnt       (cnt),
        .word_done (word_done)
    );
    assign bus.q         = q;
    assign bus.sout_r    = q[0];
    assign bus.sout_l    = q[WIDTH-1];
    assign bus.cnt       = cnt;
    assign bus.word_done = word_done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed bench with a shift-count model checked every cycle; covers USR_ROTATE_EN when defined
module tb_univ_shift_reg;
    import usr_pkg::*;
    localparam int W  = 8;
    localparam int CW = $clog2(W);
    logic clk = 1'b0;
    logic clr = 1'b0;
    logic mon = 1'b0;
    int checks = 0;
    int failures = 0;
    univ_shift_reg_if #(.WIDTH(W)) bus ();
    univ_shift_reg #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));
    always #5 clk = ~clk;
    logic [W-1:0] mq;
    int           nsh;
    logic         mwd;
    logic         mrot, rin, lin;
`ifdef USR_ROTATE_EN
    assign mrot = bus.rot;
`else
    assign mrot = 1'b0;
`endif
    assign rin = mrot ? mq[0] : bus.sin_r;
    assign lin = mrot ? mq[W-1] : bus.sin_l;
    // model: total shifts since load/reset, word completes whenever that total is a multiple of W
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mq <= '0; nsh <= 0; mwd <= 1'b0;
        end else if (bus.en && bus.mode == MODE_SHR) begin
            mq  <= (mq >> 1) | (W'(rin) << (W - 1));
            nsh <= nsh + 1;
            mwd <= ((nsh + 1) % W) == 0;
        end else if (bus.en && bus.mode == MODE_SHL) begin
            mq  <= (mq << 1) | W'(lin);
            nsh <= nsh + 1;
            mwd <= ((nsh + 1) % W) == 0;
        end else if (bus.en && bus.mode == MODE_LOAD) begin
            mq <= bus.d; nsh <= 0; mwd <= 1'b0;
        end else begin
            mwd <= 1'b0;
        end
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (mon) begin
            check("q", 32'(bus.q), 32'(mq));
            check("sout_r", 32'(bus.sout_r), 32'(mq[0]));
            check("sout_l", 32'(bus.sout_l), 32'(mq[W-1]));
            check("cnt", 32'(bus.cnt), 32'(nsh % W));
            check("word_done", 32'(bus.word_done), 32'(mwd));
        end
    end
    task automatic step(input mode_t m, input logic e, input logic [W-1:0] dd,
                        input logic sr, input logic sl);
        bus.mode = m; bus.en = e; bus.d = dd; bus.sin_r = sr; bus.sin_l = sl;
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_clr();
        #1 clr = 1'b1;
        #1;
        check("clr_q", 32'(bus.q), 32'h0);
        check("clr_cnt", 32'(bus.cnt), 32'h0);
        check("clr_wd", 32'(bus.word_done), 32'h0);
        check("clr_sout", 32'({bus.sout_l, bus.sout_r}), 32'h0);
        #1 clr = 1'b0;
    endtask
    initial begin
        bus.en = 1'b0; bus.mode = MODE_HOLD; bus.d = '0; bus.sin_r = 1'b0; bus.sin_l = 1'b0;
`ifdef USR_ROTATE_EN
        bus.rot = 1'b0;
`endif
        @(posedge clk);
        pulse_clr();
        mon = 1'b1;
        // load then one right shift
        step(MODE_LOAD, 1'b1, 8'hA5, 1'b0, 1'b0);
        check("load_q", 32'(bus.q), 32'hA5);
        check("load_cnt", 32'(bus.cnt), 32'h0);
        step(MODE_SHR, 1'b1, 8'h00, 1'b0, 1'b0);
        check("shr_q", 32'(bus.q), 32'h52);
        check("shr_sout_r", 32'(bus.sout_r), 32'h0);
        check("shr_cnt", 32'(bus.cnt), 32'h1);
        // eight left shifts of ones from reset, then a ninth
        pulse_clr();
        for (int i = 0; i < 8; i++) begin
            step(MODE_SHL, 1'b1, 8'h00, 1'b0, 1'b1);
            check("shl_wd", 32'(bus.word_done), 32'(i == 7));
        end
        check("shl8_q", 32'(bus.q), 32'hFF);
        check("shl8_cnt", 32'(bus.cnt), 32'h0);
        step(MODE_SHL, 1'b1, 8'h00, 1'b0, 1'b1);
        check("shl9_cnt", 32'(bus.cnt), 32'h1);
        check("shl9_wd", 32'(bus.word_done), 32'h0);
        // async clear mid-word
        pulse_clr();
        for (int i = 0; i < 3; i++) step(MODE_SHR, 1'b1, 8'h00, 1'b1, 1'b0);
        check("three_cnt", 32'(bus.cnt), 32'h3);
        check("three_q", 32'(bus.q), 32'hE0);
        pulse_clr();
        // enable low blocks a load
        step(MODE_LOAD, 1'b1, 8'h5A, 1'b0, 1'b0);
        step(MODE_SHR, 1'b1, 8'h00, 1'b1, 1'b0);
        step(MODE_SHR, 1'b1, 8'h00, 1'b1, 1'b0);
        check("pre_en_q", 32'(bus.q), 32'hD6);
        for (int i = 0; i < 4; i++) begin
            step(MODE_LOAD, 1'b0, 8'h3C, 1'b0, 1'b0);
            check("en0_q", 32'(bus.q), 32'hD6);
            check("en0_cnt", 32'(bus.cnt), 32'h2);
            check("en0_wd", 32'(bus.word_done), 32'h0);
        end
        // mixed directions keep counting; load mid-word restarts without a pulse
        for (int i = 0; i < 5; i++) begin
            step(i % 2 ? MODE_SHL : MODE_SHR, 1'b1, 8'h00, 1'b0, 1'b1);
            check("mix_wd", 32'(bus.word_done), 32'h0);
        end
        check("mix_cnt", 32'(bus.cnt), 32'h7);
        step(MODE_LOAD, 1'b1, 8'h0F, 1'b0, 1'b0);
        check("reload_wd", 32'(bus.word_done), 32'h0);
        for (int i = 0; i < 7; i++) begin
            step(MODE_SHL, 1'b1, 8'h00, 1'b0, 1'b0);
            check("post_load_wd", 32'(bus.word_done), 32'h0);
        end
        check("post_load_cnt", 32'(bus.cnt), 32'h7);
        step(MODE_SHR, 1'b1, 8'h00, 1'b1, 1'b0);
        check("eighth_wd", 32'(bus.word_done), 32'h1);
        check("eighth_cnt", 32'(bus.cnt), 32'h0);
        // back-to-back word with no gap
        for (int i = 0; i < 8; i++) begin
            step(MODE_SHR, 1'b1, 8'h00, 1'b0, 1'b0);
            check("b2b_wd", 32'(bus.word_done), 32'(i == 7));
        end
        step(MODE_HOLD, 1'b1, 8'h00, 1'b0, 1'b0);
        check("hold_wd", 32'(bus.word_done), 32'h0);
`ifdef USR_ROTATE_EN
        bus.rot = 1'b1;
        step(MODE_LOAD, 1'b1, 8'h81, 1'b0, 1'b0);
        step(MODE_SHR, 1'b1, 8'h00, 1'b0, 1'b0);
        check("rot_r_q", 32'(bus.q), 32'hC0);
        step(MODE_LOAD, 1'b1, 8'h81, 1'b0, 1'b0);
        step(MODE_SHL, 1'b1, 8'h00, 1'b0, 1'b0);
        check("rot_l_q", 32'(bus.q), 32'h03);
        check("rot_cnt", 32'(bus.cnt), 32'h1);
        bus.rot = 1'b0;
`endif
        step(MODE_LOAD, 1'b1, 8'h81, 1'b0, 1'b0);
        step(MODE_SHR, 1'b1, 8'h00, 1'b0, 1'b0);
        check("norot_q", 32'(bus.q), 32'h40);
        step(MODE_HOLD, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        mon = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
